// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte channel between NUM_REQ requesters.
// A lock is held from grant until the winner's last byte, or until it stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_valid,
    output logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_evt
);

    localparam int unsigned PTR_W   = $clog2(NUM_REQ);
    localparam int unsigned STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         state_q,    state_d;
    logic [PTR_W-1:0]   ptr_q,      ptr_d;
    logic [PTR_W-1:0]   grant_q,    grant_d;
    logic [STALL_W-1:0] stall_q,    stall_d;
    logic               tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]  tx_data_q,  tx_data_d;
    logic               evt_q,      evt_d;

    logic [DATA_W-1:0]  req_bytes [NUM_REQ];
    logic               gnt_valid;
    logic               gnt_last;
    logic [DATA_W-1:0]  gnt_data;
    logic               accept;
    logic               arb_found;
    logic [PTR_W-1:0]   arb_winner;
    logic [PTR_W-1:0]   cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end

    assign gnt_valid = req_valid[grant_q];
    assign gnt_last  = req_last[grant_q];
    assign gnt_data  = req_bytes[grant_q];

    // A byte moves only if the output register is empty or draining this cycle.
    assign accept = (state_q == ST_LOCKED) && gnt_valid && (!tx_valid_q || tx_ready) && !reset;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    // Round-robin search starting one past the last packet owner.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = ptr_q;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found  = 1'b1;
                arb_winner = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        stall_d    = stall_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        evt_d      = 1'b0;

        // Output holding register keeps draining regardless of lock state.
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = gnt_data;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d = ST_LOCKED;
                    grant_d = arb_winner;
                    stall_d = '0;
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    stall_d = '0;
                    if (gnt_last) begin
                        state_d = ST_IDLE;
                        ptr_d   = grant_q;
                    end
                end else if (!gnt_valid && (TIMEOUT != 0)) begin
                    if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                        state_d = ST_IDLE;
                        ptr_d   = grant_q;
                        stall_d = '0;
                        evt_d   = 1'b1;
                    end else begin
                        stall_d = STALL_W'(stall_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            grant_q    <= '0;
            stall_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            evt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            stall_q    <= stall_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            evt_q      <= evt_d;
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q == ST_LOCKED);
    assign timeout_evt = evt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-requester instance (TIMEOUT=4) and an 8-requester
// instance (TIMEOUT=0) driven from per-requester byte queues, with hand-computed expectations.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        tx_ready;

    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy, timeout_evt;

    logic [7:0]  r8_valid, r8_last, r8_ready;
    logic [63:0] r8_data;
    logic        t8_valid;
    logic [7:0]  t8_data;
    logic [2:0]  g8_id;
    logic        b8_busy, e8_evt;

    logic        v_a [8];
    logic        l_a [8];
    logic [7:0]  d_a [8];
    logic        sel8;
    logic [7:0]  rr_seen;

    logic [7:0]  qd [8][$];
    logic        ql [8][$];

    int n_cmp;
    int n_err;

    // Row format: {busy, grant_id, tx_valid} one hex digit each, then tx_data.
    localparam logic [19:0] T3 [13] = '{
        20'h10000, 20'h101A0, 20'h001A1, 20'h12000, 20'h121C0, 20'h021C1, 20'h10000,
        20'h101A2, 20'h001A3, 20'h12000, 20'h121C2, 20'h021C3, 20'h02000};
    localparam logic [19:0] T8 [9] = '{
        20'h10000, 20'h00180, 20'h17000, 20'h071F0, 20'h10000, 20'h00181, 20'h17000,
        20'h071F1, 20'h07000};

    assign req_valid = sel8 ? 4'b0 : {v_a[3], v_a[2], v_a[1], v_a[0]};
    assign req_last  = {l_a[3], l_a[2], l_a[1], l_a[0]};
    assign req_data  = {d_a[3], d_a[2], d_a[1], d_a[0]};
    assign r8_valid  = sel8 ? {v_a[7], v_a[6], v_a[5], v_a[4], v_a[3], v_a[2], v_a[1], v_a[0]} : 8'b0;
    assign r8_last   = {l_a[7], l_a[6], l_a[5], l_a[4], l_a[3], l_a[2], l_a[1], l_a[0]};
    assign r8_data   = {d_a[7], d_a[6], d_a[5], d_a[4], d_a[3], d_a[2], d_a[1], d_a[0]};

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(4)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy), .timeout_evt(timeout_evt)
    );

    uart_tx_arbiter #(.NUM_REQ(8), .DATA_W(8), .TIMEOUT(0)) u_dut8 (
        .clk(clk), .reset(reset),
        .req_valid(r8_valid), .req_data(r8_data), .req_last(r8_last), .req_ready(r8_ready),
        .tx_valid(t8_valid), .tx_data(t8_data), .tx_ready(tx_ready),
        .grant_id(g8_id), .busy(b8_busy), .timeout_evt(e8_evt)
    );

    task automatic push(input int r, input logic [7:0] d, input logic l);
        qd[r].push_back(d);
        ql[r].push_back(l);
    endtask

    // Present queue heads, sample req_ready, clock once, pop whatever was accepted.
    task automatic cycle();
        for (int i = 0; i < 8; i++) begin
            if (qd[i].size() > 0) begin
                v_a[i] = 1'b1; d_a[i] = qd[i][0]; l_a[i] = ql[i][0];
            end else begin
                v_a[i] = 1'b0; d_a[i] = 8'h00; l_a[i] = 1'b0;
            end
        end
        #1;
        rr_seen = sel8 ? r8_ready : {4'b0, req_ready};
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (rr_seen[3'(i)]) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [19:0] e);
        logic       b, v;
        logic [3:0] g;
        logic [7:0] d;
        if (sel8) begin
            b = b8_busy; g = {1'b0, g8_id}; v = t8_valid; d = t8_data;
        end else begin
            b = busy; g = {2'b0, grant_id}; v = tx_valid; d = tx_data;
        end
        chk({tag, ".busy"},     32'(b), 32'(e[19:16]));
        chk({tag, ".grant_id"}, 32'(g), 32'(e[15:12]));
        chk({tag, ".tx_valid"}, 32'(v), 32'(e[11:8]));
        if (e[8]) chk({tag, ".tx_data"}, 32'(d), 32'(e[7:0]));
    endtask

    initial begin
        logic evt_seen;
        n_cmp = 0;
        n_err = 0;
        sel8 = 1'b0;
        reset = 1'b1;
        tx_ready = 1'b1;
        rr_seen = '0;
        for (int i = 0; i < 8; i++) begin
            v_a[i] = 1'b0; l_a[i] = 1'b0; d_a[i] = 8'h00;
        end

        // Reset held for two clocks
        cycle();
        cycle();
        chk("rst.tx_valid",    32'(tx_valid), 32'd0);
        chk("rst.tx_data",     32'(tx_data), 32'd0);
        chk("rst.req_ready",   32'(req_ready), 32'd0);
        chk("rst.busy",        32'(busy), 32'd0);
        chk("rst.grant_id",    32'(grant_id), 32'd0);
        chk("rst.timeout_evt", 32'(timeout_evt), 32'd0);
        chk("rst.busy8",       32'(b8_busy), 32'd0);
        reset = 1'b0;

        // Requester 1 three-byte packet, full throughput
        push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
        cycle(); chk("t2.c1.rr", 32'(rr_seen), 32'h0); chk_row("t2.c1", 20'h11000);
        cycle(); chk("t2.c2.rr", 32'(rr_seen), 32'h2); chk_row("t2.c2", 20'h11141);
        cycle(); chk("t2.c3.rr", 32'(rr_seen), 32'h2); chk_row("t2.c3", 20'h11142);
        cycle(); chk("t2.c4.rr", 32'(rr_seen), 32'h2); chk_row("t2.c4", 20'h01143);
        cycle(); chk("t2.c5.rr", 32'(rr_seen), 32'h0); chk_row("t2.c5", 20'h01000);

        // Requesters 0 and 2, two packets each, from reset
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1); push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b1);
        for (int k = 0; k < 13; k++) begin
            cycle();
            chk_row($sformatf("t3.e%0d", k + 1), T3[k]);
        end
        chk("t3.drained", 32'(qd[0].size() + qd[2].size()), 32'd0);

        // Backpressure mid-packet from requester 1
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
        cycle(); chk_row("t4.c1", 20'h11000);
        cycle(); chk("t4.c2.rr", 32'(rr_seen), 32'h2); chk_row("t4.c2", 20'h11110);
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("t4.hold%0d.rr", k), 32'(rr_seen), 32'h0);
            chk_row($sformatf("t4.hold%0d", k), 20'h11110);
            chk($sformatf("t4.hold%0d.evt", k), 32'(timeout_evt), 32'd0);
        end
        tx_ready = 1'b1;
        cycle(); chk("t4.r1.rr", 32'(rr_seen), 32'h2); chk_row("t4.r1", 20'h11111);
        cycle(); chk_row("t4.r2", 20'h11112);
        cycle(); chk_row("t4.r3", 20'h01113);
        cycle(); chk_row("t4.r4", 20'h01000);
        chk("t4.drained", 32'(qd[1].size()), 32'd0);

        // Requester 3 stalls mid-packet; requester 0 waiting
        push(3, 8'h30, 1'b0);
        push(0, 8'h05, 1'b1);
        cycle(); chk_row("t5.c1", 20'h13000);
        cycle(); chk("t5.c2.rr", 32'(rr_seen), 32'h8); chk_row("t5.c2", 20'h13130);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("t5.s%0d.rr", k + 1), 32'(rr_seen), 32'h0);
            chk_row($sformatf("t5.s%0d", k + 1), 20'h13000);
            chk($sformatf("t5.s%0d.evt", k + 1), 32'(timeout_evt), 32'd0);
        end
        cycle(); chk_row("t5.s4", 20'h03000); chk("t5.s4.evt", 32'(timeout_evt), 32'd1);
        cycle(); chk_row("t5.g0", 20'h10000); chk("t5.g0.evt", 32'(timeout_evt), 32'd0);
        cycle(); chk("t5.a0.rr", 32'(rr_seen), 32'h1); chk_row("t5.a0", 20'h00105);
        cycle(); chk_row("t5.end", 20'h00000);

        // Reset asserted in the middle of a requester 2 packet
        push(2, 8'h77, 1'b0); push(2, 8'h78, 1'b0); push(2, 8'h79, 1'b1);
        cycle(); chk_row("t1b.c1", 20'h12000);
        cycle(); chk("t1b.c2.rr", 32'(rr_seen), 32'h4); chk_row("t1b.c2", 20'h12177);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk($sformatf("t1b.r%0d.rr", k), 32'(rr_seen), 32'h0);
            chk_row($sformatf("t1b.r%0d", k), 20'h00000);
            chk($sformatf("t1b.r%0d.tx_data", k), 32'(tx_data), 32'h0);
            chk($sformatf("t1b.r%0d.evt", k), 32'(timeout_evt), 32'h0);
        end
        reset = 1'b0;
        qd[2].delete();
        ql[2].delete();

        // Eight requesters: pointer wrap between 7 and 0
        sel8 = 1'b1;
        push(0, 8'h80, 1'b1); push(0, 8'h81, 1'b1);
        push(7, 8'hF0, 1'b1); push(7, 8'hF1, 1'b1);
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk_row($sformatf("t8.k%0d", k + 1), T8[k]);
        end

        // TIMEOUT=0 never releases a stalled lock
        push(3, 8'h33, 1'b0);
        cycle(); chk_row("t8s.c1", 20'h13000);
        cycle(); chk("t8s.c2.rr", 32'(rr_seen), 32'h8); chk_row("t8s.c2", 20'h13133);
        evt_seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            cycle();
            evt_seen = evt_seen | e8_evt;
        end
        chk_row("t8s.stall", 20'h13000);
        chk("t8s.evt", 32'(evt_seen), 32'd0);
        push(3, 8'h34, 1'b1);
        cycle(); chk("t8s.end.rr", 32'(rr_seen), 32'h8); chk_row("t8s.end", 20'h03134);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
